parity_fifo: RTL and testbench

Synchronous show-ahead FIFO that feeds the parity checker. It accepts raw payload words from the producer and appends a parity bit according to the project-wide parity mode and bit position. It stores the protected words and presents them on a pop interface matching the checker's FIFO-side ports (valid / data / grant). A per-word corrupt control lets benches deliberately present bad parity downstream.

---
 rtl/parity_fifo.sv | 107 ++++++++++
 tb/tb_parity_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_fifo.sv
// parity_fifo: show-ahead FIFO that appends a parity bit to each payload
// and presents protected words to the parity checker.
// Ports:
//   clk, rst_ni                 clock, async active-low reset
//   push_valid_i/push_data_i    producer payload (DATA_WIDTH-1 bits)
//   push_corrupt_i              invert generated parity of this push
//   push_grant_o                FIFO can accept (not full)
//   flush_i                     synchronous clear of all entries
//   pop_valid_o/pop_data_o      stored word available (parity included)
//   pop_grant_i                 consumer pops the presented word
//   fill_o                      number of stored entries

package all_types_pkg;
    typedef enum logic {ODD, EVEN} parity_mode;
    typedef enum logic {MSB, LSB} parity_bit;
endpackage

module parity_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter all_types_pkg::parity_mode PARITY_MODE = all_types_pkg::ODD,
    parameter all_types_pkg::parity_bit PARITY_BIT_CHOICE = all_types_pkg::MSB
) (
    input  logic                        clk,
    input  logic                        rst_ni,
    input  logic                        push_valid_i,
    input  logic [DATA_WIDTH-2:0]       push_data_i,
    input  logic                        push_corrupt_i,
    output logic                        push_grant_o,
    input  logic                        flush_i,
    output logic                        pop_valid_o,
    output logic [DATA_WIDTH-1:0]       pop_data_o,
    input  logic                        pop_grant_i,
    output logic [$clog2(DEPTH):0]      fill_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic                  full;
    logic                  empty;
    logic                  par;
    logic [DATA_WIDTH-1:0] word;
    logic                  do_push;
    logic                  do_pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Same slot, opposite lap: full. Identical pointers: empty.
    assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    always_comb begin
        if (PARITY_MODE == all_types_pkg::EVEN) begin
            par = ^push_data_i;
        end else begin
            par = ~^push_data_i;
        end
        par = par ^ push_corrupt_i;
        if (PARITY_BIT_CHOICE == all_types_pkg::MSB) begin
            word = {par, push_data_i};
        end else begin
            word = {push_data_i, par};
        end
    end

    // Flush overrides any push or pop in the same cycle.
    assign do_push = push_valid_i && !full && !flush_i;
    assign do_pop  = pop_grant_i && !empty && !flush_i;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_idx] <= word;
        end
    end

    assign push_grant_o = !full;
    assign pop_valid_o  = !empty;
    assign pop_data_o   = mem[rd_idx];
    assign fill_o       = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_parity_fifo.sv
// tb_parity_fifo: scoreboard bench for parity_fifo (ODD/MSB instance) plus
// directed checks on an EVEN/LSB instance.
module tb_parity_fifo;
    import all_types_pkg::*;

    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk = 0;
    logic          rst_ni;
    logic          push_valid, push_corrupt, push_grant, flush;
    logic [DW-2:0] push_data;
    logic          pop_valid, pop_grant;
    logic [DW-1:0] pop_data;
    logic [2:0]    fill;

    logic          e_push_valid, e_push_corrupt, e_push_grant, e_flush;
    logic [DW-2:0] e_push_data;
    logic          e_pop_valid, e_pop_grant;
    logic [DW-1:0] e_pop_data;
    logic [2:0]    e_fill;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];
    int            cnt;

    always #5 clk = ~clk;

    parity_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH),
                  .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(MSB)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .push_valid_i(push_valid), .push_data_i(push_data),
        .push_corrupt_i(push_corrupt), .push_grant_o(push_grant),
        .flush_i(flush), .pop_valid_o(pop_valid), .pop_data_o(pop_data),
        .pop_grant_i(pop_grant), .fill_o(fill));

    parity_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH),
                  .PARITY_MODE(EVEN), .PARITY_BIT_CHOICE(LSB)) dut_e (
        .clk(clk), .rst_ni(rst_ni),
        .push_valid_i(e_push_valid), .push_data_i(e_push_data),
        .push_corrupt_i(e_push_corrupt), .push_grant_o(e_push_grant),
        .flush_i(e_flush), .pop_valid_o(e_pop_valid),
        .pop_data_o(e_pop_data), .pop_grant_i(e_pop_grant),
        .fill_o(e_fill));

    // Reference word: parity chosen from the count of ones in the payload.
    function automatic logic [DW-1:0] ref_word(logic [DW-2:0] d,
                                               logic c, logic even, logic msb);
        int ones;
        logic p;
        ones = $countones(d);
        if (even) p = (ones % 2) == 1;
        else      p = (ones % 2) == 0;
        p = p ^ c;
        return msb ? {p, d} : {d, p};
    endfunction

    task automatic check(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: occupancy count and expected output stream.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni || flush) begin
            exp_q.delete();
            cnt = 0;
        end else begin
            automatic bit dpush = push_valid && (cnt < DEPTH);
            automatic bit dpop  = pop_grant && (cnt > 0);
            if (dpush) exp_q.push_back(ref_word(push_data, push_corrupt,
                                                1'b0, 1'b1));
            cnt = cnt + int'(dpush) - int'(dpop);
        end
    end

    // Monitor: compares flags every cycle and data on each pop.
    always @(negedge clk) begin
        if (rst_ni) begin
            check("pop_valid", int'(pop_valid), int'(cnt != 0));
            check("push_grant", int'(push_grant), int'(cnt < DEPTH));
            check("fill", int'(fill), cnt);
            if (pop_valid && pop_grant && !flush) begin
                if (exp_q.size() == 0) begin
                    check("pop_underflow", 1, 0);
                end else begin
                    check("pop_data", int'(pop_data), int'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push1(logic [DW-2:0] d);
        push_valid = 1;
        push_data = d;
        cyc();
        push_valid = 0;
    endtask

    initial begin
        rst_ni = 0;
        {push_valid, push_corrupt, flush, pop_grant} = '0;
        push_data = '0;
        {e_push_valid, e_push_corrupt, e_flush, e_pop_grant} = '0;
        e_push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pop_valid", int'(pop_valid), 0);
        check("rst_push_grant", int'(push_grant), 1);
        check("rst_fill", int'(fill), 0);
        check("rst_pop_data", int'(pop_data), 8'h00);
        rst_ni = 1;
        cyc();
        check("idle_pop_data", int'(pop_data), 8'h00);

        // Parity formatting, ODD/MSB
        push1(7'h01);
        check("odd_01", int'(pop_data), 8'h01);
        pop_grant = 1;
        push1(7'h03);
        pop_grant = 0;
        check("odd_03", int'(pop_data), 8'h83);
        pop_grant = 1;
        cyc();
        pop_grant = 0;

        // Full and wrap-around
        for (int i = 0; i < 4; i++) push1(7'(8'h10 + i));
        check("full_fill", int'(fill), 4);
        check("full_grant", int'(push_grant), 0);
        push1(7'h15);
        check("full_ignore", int'(fill), 4);
        pop_grant = 1;
        cyc();
        pop_grant = 0;
        check("release_grant", int'(push_grant), 1);
        push1(7'h14);
        pop_grant = 1;
        repeat (4) cyc();
        pop_grant = 0;
        check("drain_fill", int'(fill), 0);

        // Simultaneous push/pop at fill 2
        push1(7'h21);
        push1(7'h22);
        push_valid = 1;
        pop_grant = 1;
        for (int i = 0; i < 6; i++) begin
            push_data = 7'($urandom);
            cyc();
            check("simul_fill", int'(fill), 2);
        end
        push_valid = 0;
        repeat (2) cyc();
        pop_grant = 0;

        // Flush with concurrent push and pop
        for (int i = 0; i < 3; i++) push1(7'(8'h30 + i));
        flush = 1;
        push_valid = 1;
        pop_grant = 1;
        cyc();
        {flush, push_valid, pop_grant} = '0;
        check("flush_fill", int'(fill), 0);
        check("flush_valid", int'(pop_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            push_valid = 1'($urandom);
            push_data = 7'($urandom);
            push_corrupt = ($urandom_range(0, 7) == 0);
            pop_grant = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            cyc();
        end
        {push_valid, push_corrupt, pop_grant, flush} = '0;

        // Async reset between edges
        cyc();
        push1(7'h41);
        push1(7'h42);
        #3;
        rst_ni = 0;
        #1;
        check("arst_valid", int'(pop_valid), 0);
        check("arst_fill", int'(fill), 0);
        check("arst_grant", int'(push_grant), 1);
        check("arst_data", int'(pop_data), 8'h00);
        cyc();
        rst_ni = 1;
        cyc();

        // EVEN/LSB instance
        e_push_valid = 1;
        e_push_data = 7'h01;
        cyc();
        e_push_valid = 0;
        check("even_01", int'(e_pop_data), 8'h03);
        e_pop_grant = 1;
        cyc();
        e_pop_grant = 0;
        e_push_valid = 1;
        e_push_data = 7'h00;
        cyc();
        e_push_valid = 0;
        check("even_00", int'(e_pop_data), 8'h00);
        check("even_valid", int'(e_pop_valid), 1);
        e_pop_grant = 1;
        cyc();
        e_pop_grant = 0;
        e_push_valid = 1;
        e_push_corrupt = 1;
        e_push_data = 7'h01;
        cyc();
        e_push_valid = 0;
        e_push_corrupt = 0;
        check("even_corrupt", int'(e_pop_data), 8'h02);
        check("even_fill", int'(e_fill), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
